// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexed seven-segment anode scanner with prescaler, blanking and digit mask
module display_scan_controller #(
    parameter int NUM_DIGITS       = 4,
    parameter int PRESCALE         = 100000,
    parameter int BLANK_CYCLES     = 2000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter int SEL_W            = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sync_clear,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [SEL_W-1:0]      refresh_count,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  slot_tick,
    output logic                  frame_tick
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [NUM_DIGITS-1:0] OFF = ANODE_ACTIVE_LOW ? '1 : '0;

    logic [PW-1:0]         pcnt;
    logic [PW-1:0]         pcnt_n;
    logic [SEL_W-1:0]      idx_n;
    logic                  adv;
    logic                  wrap;
    logic                  lit;
    logic [NUM_DIGITS-1:0] onehot;

    // next-state scan position; outputs are decoded from it so anode always matches refresh_count
    always_comb begin
        adv    = enable && !sync_clear;
        wrap   = adv && (pcnt == PW'(PRESCALE - 1));
        pcnt_n = (sync_clear || wrap) ? '0 : adv ? pcnt + PW'(1) : pcnt;
        idx_n  = sync_clear ? '0 :
                 !wrap ? refresh_count :
                 (refresh_count == SEL_W'(NUM_DIGITS - 1)) ? '0 : refresh_count + SEL_W'(1);
        onehot = NUM_DIGITS'(1) << idx_n;
        lit    = enable && (int'(pcnt_n) >= BLANK_CYCLES) && digit_mask[idx_n];
    end

    // register scan state and all outputs; XOR with OFF applies anode polarity
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt          <= '0;
            refresh_count <= '0;
            anode         <= OFF;
            slot_tick     <= 1'b0;
            frame_tick    <= 1'b0;
        end else begin
            pcnt          <= pcnt_n;
            refresh_count <= idx_n;
            anode         <= lit ? (onehot ^ OFF) : OFF;
            slot_tick     <= wrap;
            frame_tick    <= wrap && (idx_n == '0);
        end
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: randomized and directed checks of two scanner configurations against a frame-position model
module tb_display_scan_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       sclr = 1'b0;
    logic [3:0] mask_a = 4'hf;
    logic [2:0] mask_b = 3'h7;
    logic [1:0] rc_a, rc_b;
    logic [3:0] an_a;
    logic [2:0] an_b;
    logic       st_a, ft_a, st_b, ft_b;
    int         pa = 0, pb = 0;
    int         n_checks = 0, n_fail = 0;
    logic [7:0] ea = 8'h3c;
    logic [6:0] eb = 7'h1c;

    always #5 clk = ~clk;

    display_scan_controller #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .ANODE_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .reset(rst), .enable(en), .sync_clear(sclr), .digit_mask(mask_a),
        .refresh_count(rc_a), .anode(an_a), .slot_tick(st_a), .frame_tick(ft_a));

    display_scan_controller #(.NUM_DIGITS(3), .PRESCALE(2), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .reset(rst), .enable(en), .sync_clear(sclr), .digit_mask(mask_b),
        .refresh_count(rc_b), .anode(an_b), .slot_tick(st_b), .frame_tick(ft_b));

    // pos is the cycle position within the frame: digit = pos / p, prescaler = pos % p
    task automatic model(inout int pos, input int n, input int p, input int b, input logic [7:0] m,
                         output logic [7:0] an, output int idx, output bit st, output bit ft);
        st = 1'b0;
        ft = 1'b0;
        if (rst || sclr) pos = 0;
        else if (en) begin
            pos = (pos + 1) % (n * p);
            st  = (pos % p) == 0;
            ft  = pos == 0;
        end
        idx = pos / p;
        an  = 8'hff;
        if (!rst && en && (pos % p) >= b && m[idx]) an[idx] = 1'b0;
    endtask

    task automatic tick();
        logic [7:0] an;
        int i;
        bit s, f;
        @(posedge clk);
        model(pa, 4, 4, 1, {4'h0, mask_a}, an, i, s, f);
        ea = {i[1:0], an[3:0], s, f};
        model(pb, 3, 2, 0, {5'h00, mask_b}, an, i, s, f);
        eb = {i[1:0], an[2:0], s, f};
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (rc_a !== 2'd0) begin n_fail++; $display("FAIL reset_rc_a got %0d want 0", rc_a); end
        n_checks++; if (an_a !== 4'hf) begin n_fail++; $display("FAIL reset_an_a got %b want 1111", an_a); end
        n_checks++; if ({st_a, ft_a} !== 2'b00) begin n_fail++; $display("FAIL reset_ticks_a got %b want 00", {st_a, ft_a}); end
        n_checks++; if (rc_b !== 2'd0) begin n_fail++; $display("FAIL reset_rc_b got %0d want 0", rc_b); end
        n_checks++; if (an_b !== 3'h7) begin n_fail++; $display("FAIL reset_an_b got %b want 111", an_b); end
        n_checks++; if ({st_b, ft_b} !== 2'b00) begin n_fail++; $display("FAIL reset_ticks_b got %b want 00", {st_b, ft_b}); end
        rst = 1'b0;
    endtask

    task automatic test_basic_scan();
        int ns = 0, nf = 0, nfb = 0;
        en = 1'b1;
        mask_a = 4'hf;
        mask_b = 3'h7;
        for (int c = 0; c < 48; c++) begin
            tick();
            ns += int'(st_a);
            nf += int'(ft_a);
            nfb += int'(ft_b);
            n_checks++; if ({rc_a, an_a, st_a, ft_a} !== ea) begin n_fail++; $display("FAIL basic_a cyc %0d got %h want %h", c, {rc_a, an_a, st_a, ft_a}, ea); end
            n_checks++; if ({rc_b, an_b, st_b, ft_b} !== eb) begin n_fail++; $display("FAIL wrap3_b cyc %0d got %h want %h", c, {rc_b, an_b, st_b, ft_b}, eb); end
        end
        n_checks++; if (ns != 12) begin n_fail++; $display("FAIL basic_slot_ticks got %0d want 12", ns); end
        n_checks++; if (nf != 3) begin n_fail++; $display("FAIL basic_frame_ticks got %0d want 3", nf); end
        n_checks++; if (nfb != 8) begin n_fail++; $display("FAIL wrap3_frame_ticks got %0d want 8", nfb); end
    endtask

    task automatic test_mask();
        mask_a = 4'b0101;
        mask_b = 3'b010;
        for (int c = 0; c < 32; c++) begin
            tick();
            n_checks++; if ({rc_a, an_a, st_a, ft_a} !== ea) begin n_fail++; $display("FAIL mask_a cyc %0d got %h want %h", c, {rc_a, an_a, st_a, ft_a}, ea); end
            n_checks++; if ({rc_b, an_b, st_b, ft_b} !== eb) begin n_fail++; $display("FAIL mask_b cyc %0d got %h want %h", c, {rc_b, an_b, st_b, ft_b}, eb); end
        end
        mask_a = 4'hf;
        mask_b = 3'h7;
    endtask

    task automatic test_enable_hold();
        for (int k = 0; k < 64 && pa != 10; k++) tick();
        n_checks++; if (pa != 10) begin n_fail++; $display("FAIL hold_reach got pos %0d want 10", pa); end
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if ({rc_a, an_a, st_a, ft_a} !== {2'd2, 4'hf, 2'b00}) begin n_fail++; $display("FAIL hold_a cyc %0d got %h want %h", c, {rc_a, an_a, st_a, ft_a}, {2'd2, 4'hf, 2'b00}); end
            n_checks++; if ({rc_b, an_b, st_b, ft_b} !== eb) begin n_fail++; $display("FAIL hold_b cyc %0d got %h want %h", c, {rc_b, an_b, st_b, ft_b}, eb); end
        end
        en = 1'b1;
        tick();
        n_checks++; if ({rc_a, an_a, st_a, ft_a} !== ea) begin n_fail++; $display("FAIL resume_a got %h want %h", {rc_a, an_a, st_a, ft_a}, ea); end
        tick();
        n_checks++; if ({rc_a, st_a} !== 3'b111) begin n_fail++; $display("FAIL resume_adv got rc %0d tick %b want rc 3 tick 1", rc_a, st_a); end
    endtask

    task automatic test_sync_clear();
        for (int k = 0; k < 64 && pa != 15; k++) tick();
        n_checks++; if (pa != 15) begin n_fail++; $display("FAIL clr_reach got pos %0d want 15", pa); end
        sclr = 1'b1;
        en = 1'b1;
        tick();
        sclr = 1'b0;
        n_checks++; if ({rc_a, an_a, st_a, ft_a} !== {2'd0, 4'hf, 2'b00}) begin n_fail++; $display("FAIL clr_a got %h want %h", {rc_a, an_a, st_a, ft_a}, {2'd0, 4'hf, 2'b00}); end
        n_checks++; if ({rc_b, an_b, st_b, ft_b} !== eb) begin n_fail++; $display("FAIL clr_b got %h want %h", {rc_b, an_b, st_b, ft_b}, eb); end
        tick();
        n_checks++; if ({rc_a, an_a, st_a, ft_a} !== ea) begin n_fail++; $display("FAIL clr_next_a got %h want %h", {rc_a, an_a, st_a, ft_a}, ea); end
    endtask

    task automatic test_reset_mid();
        int k;
        for (k = 0; k < 64 && pa != 9; k++) tick();
        n_checks++; if (pa != 9) begin n_fail++; $display("FAIL rstmid_reach got pos %0d want 9", pa); end
        #2 rst = 1'b1;
        pa = 0;
        pb = 0;
        ea = {2'd0, 4'hf, 2'b00};
        eb = {2'd0, 3'h7, 2'b00};
        #1;
        n_checks++; if ({rc_a, an_a, st_a, ft_a} !== ea) begin n_fail++; $display("FAIL rstmid_a got %h want %h", {rc_a, an_a, st_a, ft_a}, ea); end
        n_checks++; if ({rc_b, an_b, st_b, ft_b} !== eb) begin n_fail++; $display("FAIL rstmid_b got %h want %h", {rc_b, an_b, st_b, ft_b}, eb); end
        #1 rst = 1'b0;
        for (k = 1; k <= 8; k++) begin
            tick();
            n_checks++; if ({rc_a, an_a, st_a, ft_a} !== ea) begin n_fail++; $display("FAIL rstmid_run cyc %0d got %h want %h", k, {rc_a, an_a, st_a, ft_a}, ea); end
            if (st_a) break;
        end
        n_checks++; if (k != 4 || rc_a !== 2'd1) begin n_fail++; $display("FAIL rstmid_first_tick got cyc %0d rc %0d want cyc 4 rc 1", k, rc_a); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en = $urandom_range(0, 9) != 0;
            sclr = $urandom_range(0, 29) == 0;
            mask_a = 4'($urandom);
            mask_b = 3'($urandom);
            tick();
            n_checks++; if ({rc_a, an_a, st_a, ft_a} !== ea) begin n_fail++; $display("FAIL rand_a cyc %0d got %h want %h", c, {rc_a, an_a, st_a, ft_a}, ea); end
            n_checks++; if ({rc_b, an_b, st_b, ft_b} !== eb) begin n_fail++; $display("FAIL rand_b cyc %0d got %h want %h", c, {rc_b, an_b, st_b, ft_b}, eb); end
        end
        en = 1'b1;
        sclr = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_scan();
        test_mask();
        test_enable_hold();
        test_sync_clear();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
